// File: rtl/result_packer.sv
// result_packer: packs pairs of DATA_W-bit engine samples into 2*DATA_W-bit
// FIFO words, low half first. A DEPTH-entry word queue absorbs result FIFO
// backpressure. On flush, a trailing odd sample is zero-padded. flush_done
// pulses once the queue has drained.
// Optional feature macro: PACKER_STATS_EN enables the word_count counter.
module result_packer #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                flush,
   output logic                in_ready,
   input  logic                fifo_full,
   output logic                fifo_wr_en,
   output logic [2*DATA_W-1:0] fifo_din,
   output logic                flush_done,
   output logic                overflow,
   output logic [31:0]         word_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_READY = CNT_W'(DEPTH - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HALF  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state_r, state_nx;
   logic [DATA_W-1:0]   hold_r;
   logic [2*DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0]    count_r;
   logic                overflow_r;

   logic                push, push_ok, pop;
   logic                hold_load, drop_sample;
   logic [2*DATA_W-1:0] push_word;
   logic                queue_empty, queue_full;

   assign queue_empty = (count_r == '0);
   assign queue_full  = (count_r == CNT_FULL);
   assign pop         = !queue_empty && !fifo_full;
   // A push into a full queue still lands when the head pops this cycle.
   assign push_ok     = push && (!queue_full || pop);

   assign fifo_wr_en  = pop;
   assign fifo_din    = queue_empty ? '0 : mem_r[rd_ptr_r];
   assign in_ready    = (count_r <= CNT_READY);
   assign flush_done  = (state_r == DRAIN) && queue_empty;
   assign overflow    = overflow_r;

   // Next-state and packing decisions; flush is applied after the same-cycle sample.
   always_comb begin
      state_nx    = state_r;
      push        = 1'b0;
      push_word   = '0;
      hold_load   = 1'b0;
      drop_sample = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_valid && flush) begin
               push      = 1'b1;
               push_word = {{DATA_W{1'b0}}, in_data};
               state_nx  = DRAIN;
            end else if (in_valid) begin
               hold_load = 1'b1;
               state_nx  = HALF;
            end else if (flush) begin
               state_nx  = DRAIN;
            end
         end
         HALF: begin
            if (in_valid) begin
               push      = 1'b1;
               push_word = {in_data, hold_r};
               state_nx  = flush ? DRAIN : IDLE;
            end else if (flush) begin
               push      = 1'b1;
               push_word = {{DATA_W{1'b0}}, hold_r};
               state_nx  = DRAIN;
            end
         end
         DRAIN: begin
            drop_sample = in_valid;
            if (queue_empty) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register and pending low half-word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         hold_r  <= '0;
      end else begin
         state_r <= state_nx;
         if (hold_load) begin
            hold_r <= in_data;
         end
      end
   end

   // Queue storage; unreset since fifo_din masks the head while empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_r[wr_ptr_r] <= push_word;
      end
   end

   // Queue pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_ok, pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky loss flag: word dropped at a full queue or sample arriving in DRAIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_r <= 1'b0;
      end else if (drop_sample || (push && !push_ok)) begin
         overflow_r <= 1'b1;
      end
   end

`ifdef PACKER_STATS_EN
   logic [31:0] word_count_r;

   // Count of words written to the result FIFO, wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_count_r <= '0;
      end else if (pop) begin
         word_count_r <= word_count_r + 32'd1;
      end
   end

   assign word_count = word_count_r;
`else
   assign word_count = '0;
`endif

endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: directed scenarios for result_packer with a queue-based
// reference model compared on every falling edge, plus literal expectations.
module tb_result_packer;

   localparam int DW    = 16;
   localparam int DEPTH = 4;
`ifdef PACKER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          flush;
   logic          in_ready;
   logic          fifo_full;
   logic          fifo_wr_en;
   logic [2*DW-1:0] fifo_din;
   logic          flush_done;
   logic          overflow;
   logic [31:0]   word_count;

   int errors = 0;
   int checks = 0;

   result_packer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .flush      (flush),
      .in_ready   (in_ready),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .flush_done (flush_done),
      .overflow   (overflow),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model state
   logic [31:0]   mq [$];
   logic          m_pend, m_drain, m_ovf, m_init;
   logic [DW-1:0] m_hold;
   int unsigned   m_wc;
   logic [31:0]   log_q [$];
   logic [31:0]   want [$];
   int            done_cnt;

   initial begin
      m_init = 1'b0; m_pend = 1'b0; m_drain = 1'b0; m_ovf = 1'b0;
      m_hold = '0; m_wc = 0; done_cnt = 0;
   end

   // Per-cycle compare of DUT outputs against the model, then advance the model
   // using the inputs that the next rising edge will sample.
   always @(negedge clk) begin
      int sz;
      logic m_push, m_pop;
      logic [31:0] w;
      if (m_init) begin
         check("wr_en", {31'd0, fifo_wr_en}, {31'd0, (mq.size() != 0) && !fifo_full});
         check("din", fifo_din, (mq.size() != 0) ? mq[0] : 32'd0);
         check("flush_done", {31'd0, flush_done}, {31'd0, m_drain && (mq.size() == 0)});
         check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
         check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() <= DEPTH - 2});
         check("word_count", word_count, STATS ? m_wc : 32'd0);
         if (fifo_wr_en) log_q.push_back(fifo_din);
         if (flush_done) done_cnt++;
         if ((mq.size() != 0) && !fifo_full) m_wc++;
      end
      if (rst) begin
         mq.delete();
         m_pend = 1'b0; m_drain = 1'b0; m_ovf = 1'b0; m_hold = '0; m_wc = 0;
         m_init = 1'b1;
      end else if (m_init) begin
         sz = mq.size();
         m_pop = (sz != 0) && !fifo_full;
         m_push = 1'b0;
         w = '0;
         if (m_drain) begin
            if (in_valid) m_ovf = 1'b1;
            if (sz == 0) m_drain = 1'b0;
         end else begin
            if (in_valid) begin
               if (m_pend) begin
                  m_push = 1'b1; w = {in_data, m_hold}; m_pend = 1'b0;
               end else if (flush) begin
                  m_push = 1'b1; w = {16'h0000, in_data};
               end else begin
                  m_pend = 1'b1; m_hold = in_data;
               end
            end else if (flush && m_pend) begin
               m_push = 1'b1; w = {16'h0000, m_hold}; m_pend = 1'b0;
            end
            if (flush) begin
               m_drain = 1'b1; m_pend = 1'b0;
            end
         end
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            if (sz < DEPTH || m_pop) mq.push_back(w);
            else m_ovf = 1'b1;
         end
      end
   end

   task automatic drive(input logic r, input logic v, input logic [DW-1:0] d,
                        input logic f, input logic full);
      rst = r; in_valid = v; in_data = d; flush = f; fifo_full = full;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic check_log(input string name);
      check({name, "_len"}, log_q.size(), want.size());
      for (int i = 0; i < want.size() && i < log_q.size(); i++)
         check(name, log_q[i], want[i]);
   endtask

   task automatic check_reset_outputs();
      check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
      check("rst_din", fifo_din, 32'd0);
      check("rst_flush_done", {31'd0, flush_done}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_word_count", word_count, 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; fifo_full = 1'b0;
      drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
      check_reset_outputs();

      // Pair of samples -> one word one cycle after the second sample
      log_q.delete();
      drive(1'b0, 1'b1, 16'h1111, 1'b0, 1'b0);
      check("s1_no_early_wr", {31'd0, fifo_wr_en}, 32'd0);
      drive(1'b0, 1'b1, 16'h2222, 1'b0, 1'b0);
      check("s1_wr_en", {31'd0, fifo_wr_en}, 32'd1);
      check("s1_din", fifo_din, 32'h2222_1111);
      idle(3);
      want = '{32'h2222_1111};
      check_log("s1_log");

      // Odd sample count then flush -> padded trailing word and flush_done
      log_q.delete(); done_cnt = 0;
      drive(1'b0, 1'b1, 16'h000A, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 16'h000B, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check("s2_pad_wr", {31'd0, fifo_wr_en}, 32'd1);
      check("s2_done_early", {31'd0, flush_done}, 32'd0);
      idle(1);
      check("s2_done", {31'd0, flush_done}, 32'd1);
      idle(1);
      check("s2_done_pulse", {31'd0, flush_done}, 32'd0);
      idle(2);
      want = '{32'h000B_000A, 32'h0000_000C};
      check_log("s2_log");
      check("s2_done_cnt", done_cnt, 32'd1);

      // Backpressure: fill queue exactly, then release
      log_q.delete();
      for (int i = 1; i <= 8; i++) begin
         drive(1'b0, 1'b1, 16'h3000 + 16'(i), 1'b0, 1'b1);
         if (i == 4) check("s3_ready_2w", {31'd0, in_ready}, 32'd1);
         if (i == 6) check("s3_ready_3w", {31'd0, in_ready}, 32'd0);
      end
      check("s3_ovf", {31'd0, overflow}, 32'd0);
      check("s3_held", {31'd0, fifo_wr_en}, 32'd0);
      fifo_full = 1'b0;
      #1;
      check("s3_release_wr", {31'd0, fifo_wr_en}, 32'd1);
      check("s3_release_din", fifo_din, 32'h3002_3001);
      idle(6);
      want = '{32'h3002_3001, 32'h3004_3003, 32'h3006_3005, 32'h3008_3007};
      check_log("s3_log");

      // Overrun: fifth word dropped
      log_q.delete();
      for (int i = 1; i <= 10; i++) begin
         drive(1'b0, 1'b1, 16'h4000 + 16'(i), 1'b0, 1'b1);
         if (i == 8) check("s4_ovf_before", {31'd0, overflow}, 32'd0);
      end
      check("s4_ovf", {31'd0, overflow}, 32'd1);
      idle(6);
      want = '{32'h4002_4001, 32'h4004_4003, 32'h4006_4005, 32'h4008_4007};
      check_log("s4_log");
      check("s4_ovf_sticky", {31'd0, overflow}, 32'd1);
      check("total_words", word_count, STATS ? 32'd11 : 32'd0);

      // Sample with flush from IDLE -> one padded word, then flush_done
      drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
      check_reset_outputs();
      log_q.delete(); done_cnt = 0;
      drive(1'b0, 1'b1, 16'h5555, 1'b1, 1'b0);
      idle(4);
      want = '{32'h0000_5555};
      check_log("s5_log");
      check("s5_done_cnt", done_cnt, 32'd1);

      // Reset while a half-word is pending
      log_q.delete();
      drive(1'b0, 1'b1, 16'h7777, 1'b0, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
      check_reset_outputs();
      idle(4);
      want.delete();
      check_log("s5_rst_log");

      // Sample arriving during DRAIN is dropped and flagged
      log_q.delete();
      drive(1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
      check("s6_drain_ovf", {31'd0, overflow}, 32'd1);
      idle(4);
      want = '{32'h0000_000C};
      check_log("s6_log");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/result_packer.md
# result_packer

Sits between `engine` and the result FIFO on `clk`. It takes the engine's 16-bit result stream (a write strobe plus data) and packs pairs of samples into 32-bit FIFO words, low half first. It buffers up to `DEPTH` words against FIFO backpressure, because the engine cannot be stalled. On `flush` (layer end) it pads and emits any odd trailing sample, then signals completion once everything has been written.

## Interface
- `DATA_W`, 16, input sample width
- `DEPTH`, 4, internal word queue depth (power of two, ≥2)
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  engine result strobe; one sample per cycle when high
- `in_data`  in  DATA_W  engine result sample
- `flush`  in  1  single-cycle layer-end pulse
- `in_ready`  out  1  advisory: queue has ≥2 free entries
- `fifo_full`  in  1  result FIFO full
- `fifo_wr_en`  out  1  result FIFO write enable
- `fifo_din`  out  2*DATA_W  result FIFO write data
- `flush_done`  out  1  one-cycle pulse after a flush completes
- `overflow`  out  1  sticky: a word or sample was dropped
- `word_count`  out  32  words written to FIFO (`PACKER_STATS_EN` only)

## Operation
- FSM states:
  - IDLE: no half-word pending.
  - HALF: low half held in `hold_r`.
  - DRAIN: flush accepted, waiting for the queue to empty.
- IDLE + `in_valid`: capture `in_data` into `hold_r`, go to HALF.
- HALF + `in_valid`: enqueue `{in_data, hold_r}`, go to IDLE.
- `flush` is evaluated after the same-cycle sample. If a half-word is still pending, enqueue `{16'h0000, hold_r}`. Either way, go to DRAIN.
  - HALF + sample + flush: the sample completes the word, no pad.
  - IDLE + sample + flush: one padded word `{0000, sample}`.
  - At most one word is enqueued per cycle.
- DRAIN: when the queue is empty, pulse `flush_done` for one cycle and go to IDLE.
  - `in_valid` in DRAIN is a contract violation: the sample is dropped and `overflow` is set.
  - `flush` in DRAIN is ignored.
- Queue: circular buffer with wrapping pointers and a count (0..DEPTH).
  - `fifo_wr_en = (count != 0) && !fifo_full` (combinational); `fifo_din` = head entry.
  - A pop occurs whenever `fifo_wr_en` is high.
- Push and pop in the same cycle: both happen and the count is unchanged. This is legal even when `count == DEPTH`.
- Push into a full queue with no pop: the word is dropped, `overflow` is set, and the queue contents are unchanged.
- `in_ready = (count <= DEPTH-2)`.
- `overflow` clears only on `rst`.

## Timing
- Reset values (on the edge where `rst` is high):
  - state IDLE, count 0, pointers 0, `hold_r` 0
  - `fifo_wr_en` 0, `fifo_din` 0 (empty head)
  - `flush_done` 0, `overflow` 0, `word_count` 0
- `rst` mid-operation discards the pending half-word and queued words with no flush.
- Latency: the second sample is accepted at edge N, and `fifo_wr_en` is high in cycle N+1 if the queue was empty and `fifo_full` is low.
- Throughput: one sample per cycle in, so at most one word every 2 cycles into the FIFO. The queue only fills while `fifo_full` is held.
- `flush_done` is asserted in the cycle after the edge on which the last queued word is popped. A flush with an empty queue and nothing pending gives `flush_done` at flush edge +1.
- `fifo_full` is sampled combinationally. Deasserting it enables a pop in the same cycle.

## Configuration
- `PACKER_STATS_EN` defined:
  - `word_count` increments by 1 on every cycle with `fifo_wr_en` high.
  - It wraps at 2^32 and resets to 0 on `rst`.
- `PACKER_STATS_EN` undefined:
  - The counter is not built and `word_count` is tied to 0.
  - `overflow` and all packing behaviour are unchanged.

## Test plan
- Reset, then samples 0x1111, 0x2222 on consecutive cycles with `fifo_full`=0 → a single `fifo_wr_en` with `fifo_din`=0x2222_1111, one cycle after the second sample.
- Three samples 0xA, 0xB, 0xC, then a `flush` pulse → words 0x000B_000A and 0x0000_000C, then a one-cycle `flush_done`.
- Hold `fifo_full`=1 and send 8 samples (DEPTH=4):
  - `in_ready` drops after the 3rd word and `overflow` stays 0.
  - Release `fifo_full` → 4 words are written in order on 4 consecutive cycles.
- Hold `fifo_full`=1 and send 10 samples → the 5th word is dropped and `overflow`=1. After release, only words 1–4 appear.
- Sample 0x5555 in the same cycle as `flush` from IDLE → exactly one word 0x0000_5555, then `flush_done`. Also assert `rst` while in HALF → no word is emitted and all outputs return to their reset values.
- With `PACKER_STATS_EN`, after the scenarios above, `word_count` equals the number of cycles with `fifo_wr_en` high. Without the macro, it reads 0.
